// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MEM-stage data-memory responder with fixed wait states
module dmem_access_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memwrite,
    input  logic [1:0]  lwhb,
    input  logic [1:0]  swhb,
    input  logic        lunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept;
    logic          commit;

    logic          mw_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          acc_err;
    logic [3:0]    be;
    logic [31:0]   wd_rep;
    logic [31:0]   ld_ext;

    // Next-state logic: accept in IDLE, count down wait states, one-cycle response
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request; size comes from the store or load field depending on direction
    always_ff @(posedge clk) begin
        if (!reset) begin
            mw_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            mw_q    <= memwrite;
            size_q  <= memwrite ? swhb : lwhb;
            uns_q   <= lunsigned;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
        end
    end

    // Access decode: alignment check, byte enables, lane replication and load extension
    always_comb begin
        word_idx = addr_q[AW+1:2];
        rd_word  = mem_q[word_idx];
        lane_b   = rd_word[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = rd_word[{addr_q[1], 4'b0000} +: 16];
        acc_err  = (size_q == 2'b00)
                 | ((size_q == 2'b11) && (addr_q[1:0] != 2'b00))
                 | ((size_q == 2'b10) && addr_q[0]);
        be       = 4'b0000;
        wd_rep   = {4{wdata_q[7:0]}};
        ld_ext   = 32'd0;
        case (size_q)
            2'b11: begin
                be     = 4'b1111;
                wd_rep = wdata_q;
                ld_ext = rd_word;
            end
            2'b10: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wdata_q[15:0]}};
                ld_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            2'b01: begin
                be     = 4'b0001 << addr_q[1:0];
                ld_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            default: ;
        endcase
    end

    // Response data/error, updated only at the commit edge and held otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || mw_q) ? 32'd0 : ld_ext;
        end
    end

    // RAM write port; contents survive reset, and a reset at the commit edge drops the store
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && reset && mw_q && !acc_err && be[i]) begin
                mem_q[word_idx][8*i +: 8] <= wd_rep[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory responder for the xgriscv MEM stage. It accepts a load or store request from the pipeline using the controller's memory controls (`memwrite`, `lwhb`, `swhb`, `lunsigned`), performs the access against an internal word-organised RAM after a fixed wait, and returns sign- or zero-extended load data or a store acknowledge. It also flags misaligned and illegal-size accesses.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two.
- `LATENCY`, 2: wait-state cycles between request acceptance and response; legal range 1–15.

Ports:
- `clk`  in  1  Clock.
- `reset`  in  1  Synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  Unit can accept a request.
- `memwrite`  in  1  1 = store, 0 = load.
- `lwhb`  in  2  Load size: 11 = word, 10 = half, 01 = byte, 00 = illegal.
- `swhb`  in  2  Store size, same encoding as `lwhb`.
- `lunsigned`  in  1  Zero-extend load data (lbu/lhu).
- `addr`  in  32  Byte address.
- `wdata`  in  32  Store data; the least-significant byte or half carries sub-word data.
- `resp_valid`  out  1  One-cycle response pulse.
- `rdata`  out  32  Extended load data; 0 for stores and errors.
- `err`  out  1  Misaligned or illegal-size access; valid with `resp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready` = 1. On `req_valid` with `req_ready` set, latch `memwrite`, the applicable size, `lunsigned`, `addr` and `wdata`. Load the wait counter with `LATENCY`, then go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, perform the access and go to RESP.
- RESP: assert `resp_valid` for one cycle, then return to IDLE. There is no response backpressure.
- Size is taken from `swhb` when `memwrite` = 1, otherwise from `lwhb`.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Alignment: a word access needs `addr[1:0]` = 00; a half access needs `addr[0]` = 0; a byte access is always aligned.
- An access is in error if the size is 00 or the address is misaligned. On error: no RAM write, `rdata` = 0, `err` = 1.
- Store byte enables:
  - word: 1111.
  - half: 0011 or 1100, selected by `addr[1]`.
  - byte: one-hot on `addr[1:0]`.
  - Data is replicated across lanes: byte as `{4{wdata[7:0]}}`, half as `{2{wdata[15:0]}}`.
  - Only the enabled bytes change.
- Load extraction: select the byte or half lane by `addr[1:0]` and shift it to bit 0. Sign-extend from bit 7 or bit 15 unless `lunsigned` = 1. A word load ignores `lunsigned`.
- RAM contents are not cleared by reset and are uninitialised after power-up.

## Timing
- Reset values: `req_ready` = 1, `resp_valid` = 0, `rdata` = 0, `err` = 0. State = IDLE, counter = 0.
- If a request is accepted at edge T, the RAM write or read occurs at edge T+`LATENCY`. `resp_valid`, `rdata` and `err` are high and valid during cycle T+`LATENCY`+1 only.
- `req_ready` is 0 from T+1 through the RESP cycle. It returns to 1 the cycle after RESP. Back-to-back requests are therefore spaced by `LATENCY`+2 cycles.
- A store committed at edge T+`LATENCY` is visible to any later request.
- `rdata` and `err` hold their last values outside `resp_valid`. Consumers must qualify them with `resp_valid`.
- Inputs are ignored while `req_ready` = 0. Holding `req_valid` high is legal and the request is taken on the next IDLE cycle.
- Reset asserted in WAIT before the commit edge: the access is dropped, no RAM write occurs, and no response is produced.
- Reset asserted in the RESP cycle: `resp_valid` is forced to 0 on the next edge.

## Test plan
- Word store then load, `LATENCY` = 2: sw 0xDEADBEEF at 0x100, then lw at 0x100. Expected: `rdata` = 0xDEADBEEF, `err` = 0, and each `resp_valid` occurs exactly 3 cycles after acceptance.
- Byte lanes and sign extension: sb 0x80 at 0x203 over a word of 0x00000000. Then lb at 0x203 → 0xFFFFFF80; lbu at 0x203 → 0x00000080; lw at 0x200 → 0x80000000.
- Half lanes: sh 0x1234 at 0x302, then lhu at 0x302 → 0x00001234, and lw at 0x300 → 0x1234xxxx with the low half unchanged. Repeat with sh 0x8001 and lh → 0xFFFF8001.
- Errors: lh at 0x401 and sw at 0x402 → `err` = 1, `rdata` = 0, and the RAM is unchanged. A load with `lwhb` = 00 → `err` = 1.
- Reset mid-operation: issue sw 0x11111111 at 0x500, then drop `reset` during WAIT. Expected: no `resp_valid`, and a later lw at 0x500 returns the prior value.
- Wrap and back-to-back: with `DEPTH_WORDS` = 1024, sw at 0x1000 then lw at 0x0000 returns the stored value. With `req_valid` held high, requests are accepted every `LATENCY`+2 cycles.
